// File: rtl/fifo_drain_if.sv
// ============================================================================
// Module      : fifo_drain_if
// Description : FIFO read-side and downstream valid/ready signal bundle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fifo_drain_if #(
    parameter int DATA_WIDTH = 6
);
    logic                  enable;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_rd;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  busy;
    logic                  err_rd_empty;

    modport master (
        output enable,
        output fifo_empty,
        output fifo_data,
        output out_ready,
        input  fifo_rd,
        input  out_valid,
        input  out_data,
        input  busy,
        input  err_rd_empty
    );

    modport slave (
        input  enable,
        input  fifo_empty,
        input  fifo_data,
        input  out_ready,
        output fifo_rd,
        output out_valid,
        output out_data,
        output busy,
        output err_rd_empty
    );
endinterface

`default_nettype wire

// File: rtl/fifo_drain.sv
// ============================================================================
// Module      : fifo_drain
// Description : FIFO read controller with skid buffer feeding a valid/ready
//               output. Optional handshake counter under FIFO_DRAIN_WCNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_drain #(
    parameter int DATA_WIDTH = 6,
    parameter int RD_LATENCY = 1,
    parameter int SKID_DEPTH = 2
) (
    input  wire logic     clk,
    input  wire logic     RESET_L,
    fifo_drain_if.slave   bus
`ifdef FIFO_DRAIN_WCNT_EN
    ,
    input  wire logic     cnt_clr,
    output logic [15:0]   word_cnt
`endif
);

    localparam int PTR_W = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int SUM_W = CNT_W + 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_STOP = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [DATA_WIDTH-1:0]  skid_q [SKID_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [RD_LATENCY-1:0]  inflight_q, inflight_d;
    logic                   err_q, err_d;

    logic                   w_push;
    logic                   w_pop;
    logic                   w_rd;
    logic [SUM_W-1:0]       w_inflight_n;
    logic [SUM_W-1:0]       w_occupancy;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(SKID_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_push = inflight_q[RD_LATENCY-1];
    assign w_pop  = (count_q != '0) && bus.out_ready;

    always_comb begin
        w_inflight_n = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            w_inflight_n = w_inflight_n + SUM_W'(inflight_q[i]);
        end
    end

    // A pop on this edge frees a slot before any new read can land, which is
    // what lets the drain sustain one word per cycle.
    assign w_occupancy = SUM_W'(count_q) + w_inflight_n - SUM_W'(w_pop);
    assign w_rd        = (state_q == S_RUN) && !bus.fifo_empty &&
                         (w_occupancy < SUM_W'(SKID_DEPTH));

    generate
        if (RD_LATENCY == 1) begin : g_lat1
            assign inflight_d = w_rd;
        end else begin : g_latn
            assign inflight_d = {inflight_q[RD_LATENCY-2:0], w_rd};
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.enable) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (!bus.enable) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (bus.enable) begin
                    state_d = S_RUN;
                end else if ((inflight_q == '0) && (count_q == '0)) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        err_d    = err_q | (w_rd & bus.fifo_empty);
        if (w_push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (w_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (w_push && !w_pop) begin
            count_d = count_q + 1'b1;
        end else if (!w_push && w_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge RESET_L) begin
        if (!RESET_L) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            inflight_q <= '0;
            err_q      <= 1'b0;
            for (int i = 0; i < SKID_DEPTH; i++) begin
                skid_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            err_q      <= err_d;
            if (w_push) begin
                skid_q[wr_ptr_q] <= bus.fifo_data;
            end
        end
    end

    assign bus.fifo_rd      = w_rd;
    assign bus.out_valid    = (count_q != '0);
    assign bus.out_data     = skid_q[rd_ptr_q];
    assign bus.busy         = (state_q != S_IDLE);
    assign bus.err_rd_empty = err_q;

`ifdef FIFO_DRAIN_WCNT_EN
    logic [15:0] word_cnt_q, word_cnt_d;

    always_comb begin
        word_cnt_d = word_cnt_q;
        if (cnt_clr) begin
            word_cnt_d = {15'd0, w_pop};
        end else if (w_pop) begin
            word_cnt_d = word_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge RESET_L) begin
        if (!RESET_L) begin
            word_cnt_q <= '0;
        end else begin
            word_cnt_q <= word_cnt_d;
        end
    end

    assign word_cnt = word_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo_drain.sv
// ============================================================================
// Module      : tb_fifo_drain
// Description : Scoreboard bench for fifo_drain with a one-cycle FIFO model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_drain;
    localparam int DW = 6;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;

    fifo_drain_if #(.DATA_WIDTH(DW)) bus ();

`ifdef FIFO_DRAIN_WCNT_EN
    logic        cnt_clr;
    logic [15:0] word_cnt;
`endif

    fifo_drain #(
        .DATA_WIDTH (DW),
        .RD_LATENCY (1),
        .SKID_DEPTH (2)
    ) u_dut (
        .clk      (clk),
        .RESET_L  (rst_n),
        .bus      (bus.slave)
`ifdef FIFO_DRAIN_WCNT_EN
        ,
        .cnt_clr  (cnt_clr),
        .word_cnt (word_cnt)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [DW-1:0] mem [64];
    int head = 0;
    int tail = 0;
    int rd_cnt = 0;
    int rd_empty = 0;

    assign bus.fifo_empty = (head == tail);

    always @(posedge clk) begin
        if (rst_n && bus.fifo_rd) begin
            if (head == tail) begin
                rd_empty <= rd_empty + 1;
            end else begin
                bus.fifo_data <= mem[head];
                head          <= head + 1;
            end
            rd_cnt <= rd_cnt + 1;
        end
    end

    logic [DW-1:0] exp_q [$];
    int            hs_t [$];
    int            n_vec = 0;
    int            n_err = 0;

    always @(negedge clk) begin
        logic [DW-1:0] e;
        if (rst_n && bus.out_valid && bus.out_ready) begin
            hs_t.push_back(cyc);
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL out_data unexpected: got %0h, required no word", bus.out_data);
            end else begin
                e = exp_q.pop_front();
                if (bus.out_data !== e) begin
                    n_err++;
                    $display("FAIL out_data order: got %0h, required %0h", bus.out_data, e);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", nm, act, expv);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [DW-1:0] w, input bit expect_out);
        mem[tail] = w;
        tail      = tail + 1;
        if (expect_out) exp_q.push_back(w);
    endtask

    task automatic wait_drain(input string nm, input int budget);
        int k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            tick(1);
            k++;
        end
        chk(nm, exp_q.size(), 0);
    endtask

    task automatic wait_idle(input string nm, input int budget);
        int k = 0;
        while (bus.busy && k < budget) begin
            tick(1);
            k++;
        end
        chk(nm, {31'd0, bus.busy}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global timeout: got no finish, required finish");
        $fatal(1);
    end

    initial begin
        int t0, base, rb, k;
        rst_n         = 1'b0;
        bus.enable    = 1'b0;
        bus.out_ready = 1'b0;
`ifdef FIFO_DRAIN_WCNT_EN
        cnt_clr = 1'b0;
`endif
        #1;
        chk("reset fifo_rd",   {31'd0, bus.fifo_rd},      0);
        chk("reset out_valid", {31'd0, bus.out_valid},    0);
        chk("reset busy",      {31'd0, bus.busy},         0);
        chk("reset out_data",  {26'd0, bus.out_data},     0);
        tick(2);
        rst_n = 1'b1;
        tick(1);

        // Basic drain with latency and back-to-back throughput
        for (int i = 1; i <= 8; i++) load(DW'(i), 1'b1);
        tick(2);
        chk("idle no read", rd_cnt, 0);
        base = hs_t.size();
        rb   = rd_cnt;
        t0   = cyc;
        bus.enable    = 1'b1;
        bus.out_ready = 1'b1;
        wait_drain("basic drained", 60);
        chk("basic rd count", rd_cnt - rb, 8);
        chk("basic first latency", hs_t[base] - t0, 3);
        chk("basic span", hs_t[hs_t.size()-1] - hs_t[base], 7);
        chk("basic busy", {31'd0, bus.busy}, 1);

        // Backpressure
        bus.out_ready = 1'b0;
        rb = rd_cnt;
        for (int i = 1; i <= 8; i++) load(DW'(i), 1'b1);
        tick(10);
        chk("stall rd count", rd_cnt - rb, 2);
        chk("stall out_valid", {31'd0, bus.out_valid}, 1);
        chk("stall out_data", {26'd0, bus.out_data}, 1);
        base = hs_t.size();
        bus.out_ready = 1'b1;
        wait_drain("stall drained", 60);
        chk("stall rd total", rd_cnt - rb, 8);
        chk("stall span", hs_t[hs_t.size()-1] - hs_t[base], 7);

        // Empty boundary
        rb = rd_cnt;
        load(6'h2A, 1'b1);
        tick(5);
        chk("empty one read", rd_cnt - rb, 1);
        load(6'h15, 1'b1);
        wait_drain("empty drained", 30);
        chk("empty two reads", rd_cnt - rb, 2);
        chk("read while empty", rd_empty, 0);

        // Stop and restart mid-stream
        base = hs_t.size();
        rb   = rd_cnt;
        for (int i = 1; i <= 8; i++) load(DW'(i), 1'b1);
        k = 0;
        while ((hs_t.size() - base) < 3 && k < 100) begin
            @(posedge clk);
            k++;
        end
        #1;
        chk("stop trigger", {31'd0, k < 100}, 1);
        bus.enable = 1'b0;
        wait_idle("stop reaches idle", 40);
        chk("stop rd count", rd_cnt - rb, 6);
        chk("stop delivered", hs_t.size() - base, 6);
        chk("stop pending", exp_q.size(), 2);
        bus.enable = 1'b1;
        wait_drain("restart drained", 40);
        chk("restart rd total", rd_cnt - rb, 8);

`ifdef FIFO_DRAIN_WCNT_EN
        chk("word_cnt total", {16'd0, word_cnt}, hs_t.size());
        bus.out_ready = 1'b0;
        cnt_clr = 1'b1;
        tick(1);
        cnt_clr = 1'b0;
        chk("word_cnt clear", {16'd0, word_cnt}, 0);
        for (int i = 1; i <= 8; i++) load(DW'(i), 1'b1);
        bus.out_ready = 1'b1;
        wait_drain("wcnt drained", 60);
        chk("word_cnt eight", {16'd0, word_cnt}, 8);
        bus.out_ready = 1'b0;
        load(6'h33, 1'b1);
        tick(4);
        cnt_clr       = 1'b1;
        bus.out_ready = 1'b1;
        tick(1);
        cnt_clr = 1'b0;
        chk("word_cnt clr+hs", {16'd0, word_cnt}, 1);
        wait_drain("wcnt final drained", 10);
`endif

        chk("err_rd_empty", {31'd0, bus.err_rd_empty}, 0);

        // Asynchronous reset with words buffered and in the FIFO
        bus.out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) load(DW'(8'h10 + i), 1'b0);
        tick(3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst fifo_rd",   {31'd0, bus.fifo_rd},      0);
        chk("async rst out_valid", {31'd0, bus.out_valid},    0);
        chk("async rst busy",      {31'd0, bus.busy},         0);
        chk("async rst out_data",  {26'd0, bus.out_data},     0);
        chk("async rst err",       {31'd0, bus.err_rd_empty}, 0);
        tick(2);
        bus.enable    = 1'b0;
        bus.out_ready = 1'b1;
        rb    = rd_cnt;
        rst_n = 1'b1;
        tick(5);
        chk("post rst no read", rd_cnt - rb, 0);
        chk("post rst idle", {31'd0, bus.busy}, 0);
        chk("post rst out_valid", {31'd0, bus.out_valid}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

`default_nettype wire
